// File: rtl/mem_arbiter_if.sv
// Two-requester memory arbiter bus: requester A/B request, ack and read-data
// signals plus the single-ported memory connection.
interface mem_arbiter_if #(
    parameter int BITS  = 16,
    parameter int ADDRW = 8
);
    logic             i_a_req;
    logic             i_b_req;
    logic             i_a_rw;
    logic             i_b_rw;
    logic [ADDRW-1:0] i_a_addr;
    logic [ADDRW-1:0] i_b_addr;
    logic [BITS-1:0]  i_a_data;
    logic [BITS-1:0]  i_b_data;
    logic             o_a_ack;
    logic             o_b_ack;
    logic [BITS-1:0]  o_a_data;
    logic [BITS-1:0]  o_b_data;
    logic             o_mem_rw;
    logic [ADDRW-1:0] o_mem_addr;
    logic [BITS-1:0]  o_mem_data;
    logic [BITS-1:0]  i_mem_data;
    logic             o_busy;

    modport slave (
        input  i_a_req, i_b_req, i_a_rw, i_b_rw, i_a_addr, i_b_addr,
               i_a_data, i_b_data, i_mem_data,
        output o_a_ack, o_b_ack, o_a_data, o_b_data,
               o_mem_rw, o_mem_addr, o_mem_data, o_busy
    );

    modport master (
        output i_a_req, i_b_req, i_a_rw, i_b_rw, i_a_addr, i_b_addr,
               i_a_data, i_b_data, i_mem_data,
        input  o_a_ack, o_b_ack, o_a_data, o_b_data,
               o_mem_rw, o_mem_addr, o_mem_data, o_busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between requesters A and B.
// Request seen in IDLE -> one ACCESS cycle -> ack in DONE; all outputs registered.
module mem_arbiter #(
    parameter int BITS  = 16,
    parameter int ADDRW = 8
) (
    input logic          i_clk,
    input logic          i_rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t           state_q;
    logic             winner_b_q;
    logic             last_b_q;
    logic             mem_rw_q;
    logic [ADDRW-1:0] mem_addr_q;
    logic [BITS-1:0]  mem_data_q;
    logic             a_ack_q;
    logic             b_ack_q;
    logic [BITS-1:0]  a_data_q;
    logic [BITS-1:0]  b_data_q;
    logic             busy_q;

    logic             grant_b_d;
    logic             rw_d;
    logic [ADDRW-1:0] addr_d;
    logic [BITS-1:0]  data_d;

    // B wins when it is the only requester, or when both request and A had the last grant.
    always_comb begin
        grant_b_d = bus.i_b_req && (!bus.i_a_req || !last_b_q);
        rw_d      = grant_b_d ? bus.i_b_rw   : bus.i_a_rw;
        addr_d    = grant_b_d ? bus.i_b_addr : bus.i_a_addr;
        data_d    = grant_b_d ? bus.i_b_data : bus.i_a_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            winner_b_q <= 1'b0;
            last_b_q   <= 1'b1;
            mem_rw_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            a_ack_q    <= 1'b0;
            b_ack_q    <= 1'b0;
            a_data_q   <= '0;
            b_data_q   <= '0;
            busy_q     <= 1'b0;
        end else begin
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.i_a_req || bus.i_b_req) begin
                        winner_b_q <= grant_b_d;
                        mem_rw_q   <= rw_d;
                        mem_addr_q <= addr_d;
                        mem_data_q <= data_d;
                        busy_q     <= 1'b1;
                        state_q    <= ACCESS;
                    end
                end
                ACCESS: begin
                    // mem_rw_q still carries the latched direction during this cycle.
                    if (!mem_rw_q) begin
                        if (winner_b_q) b_data_q <= bus.i_mem_data;
                        else            a_data_q <= bus.i_mem_data;
                    end
                    mem_rw_q <= 1'b0;
                    a_ack_q  <= !winner_b_q;
                    b_ack_q  <= winner_b_q;
                    state_q  <= DONE;
                end
                DONE: begin
                    last_b_q <= winner_b_q;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    mem_rw_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_a_ack    = a_ack_q;
    assign bus.o_b_ack    = b_ack_q;
    assign bus.o_a_data   = a_data_q;
    assign bus.o_b_data   = b_data_q;
    assign bus.o_mem_rw   = mem_rw_q;
    assign bus.o_mem_addr = mem_addr_q;
    assign bus.o_mem_data = mem_data_q;
    assign bus.o_busy     = busy_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected acks into a scoreboard,
// a negedge monitor pops and compares ack side, ack cycle and held read data.
module tb_mem_arbiter;
    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    always #5 i_clk = ~i_clk;

    mem_arbiter_if #(.BITS(16), .ADDRW(8)) bus ();

    mem_arbiter #(.BITS(16), .ADDRW(8)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    logic [15:0] mem [0:255];
    initial for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    assign bus.i_mem_data = mem[bus.o_mem_addr];
    always @(posedge i_clk) if (bus.o_mem_rw && !i_rst) mem[bus.o_mem_addr] <= bus.o_mem_data;

    int unsigned cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        bit          side_b;
        bit          rw;
        logic [15:0] rdata;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] held_a = 16'h0000;
    logic [15:0] held_b = 16'h0000;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge i_clk) begin
        if (bus.o_a_ack && bus.o_b_ack) chk("ack_overlap", 32'd1, 32'd0);
        if (bus.o_a_ack || bus.o_b_ack) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("ack_side_b", {31'd0, bus.o_b_ack}, {31'd0, mon_e.side_b});
                chk("ack_cycle", cyc, mon_e.cyc);
                if (!mon_e.rw) begin
                    if (mon_e.side_b) held_b = mon_e.rdata;
                    else              held_a = mon_e.rdata;
                end
                chk("a_data", {16'd0, bus.o_a_data}, {16'd0, held_a});
                chk("b_data", {16'd0, bus.o_b_data}, {16'd0, held_b});
            end
        end
    end

    task automatic drive(input bit b, input bit req, input bit rw, input logic [7:0] addr,
                         input logic [15:0] wd);
        if (b) begin
            bus.i_b_req = req; bus.i_b_rw = rw; bus.i_b_addr = addr; bus.i_b_data = wd;
        end else begin
            bus.i_a_req = req; bus.i_a_rw = rw; bus.i_a_addr = addr; bus.i_a_data = wd;
        end
    endtask

    task automatic expect_ack(input bit b, input bit rw, input logic [15:0] rd, input int unsigned c);
        exp_t e;
        e.side_b = b; e.rw = rw; e.rdata = rd; e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_mem_rw"},   {31'd0, bus.o_mem_rw}, 32'd0);
        chk({tag, "_mem_addr"}, {24'd0, bus.o_mem_addr}, 32'd0);
        chk({tag, "_mem_data"}, {16'd0, bus.o_mem_data}, 32'd0);
        chk({tag, "_acks"},     {30'd0, bus.o_a_ack, bus.o_b_ack}, 32'd0);
        chk({tag, "_a_data"},   {16'd0, bus.o_a_data}, 32'd0);
        chk({tag, "_b_data"},   {16'd0, bus.o_b_data}, 32'd0);
        chk({tag, "_busy"},     {31'd0, bus.o_busy}, 32'd0);
    endtask

    // One single-requester access; inputs are scrambled during ACCESS to prove they were latched.
    task automatic issue(input bit b, input bit rw, input logic [7:0] addr, input logic [15:0] wd,
                         input logic [15:0] exp_rd);
        drive(b, 1'b1, rw, addr, wd);
        expect_ack(b, rw, exp_rd, cyc + 2);
        @(negedge i_clk);
        chk("access_busy", {31'd0, bus.o_busy}, 32'd1);
        chk("access_rw", {31'd0, bus.o_mem_rw}, {31'd0, rw});
        chk("access_addr", {24'd0, bus.o_mem_addr}, {24'd0, addr});
        if (rw) chk("access_wdata", {16'd0, bus.o_mem_data}, {16'd0, wd});
        drive(b, 1'b0, ~rw, ~addr, ~wd);
        @(negedge i_clk);
        chk("done_rw_low", {31'd0, bus.o_mem_rw}, 32'd0);
        @(negedge i_clk);
        chk("idle_busy", {31'd0, bus.o_busy}, 32'd0);
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
        i_rst = 1'b1;
        repeat (2) @(negedge i_clk);
        check_reset_outputs("rst");
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("idle_no_req_rw", {31'd0, bus.o_mem_rw}, 32'd0);

        issue(1'b0, 1'b1, 8'h03, 16'h1234, 16'h0000);
        chk("mem3", {16'd0, mem[3]}, 32'h0000_1234);
        issue(1'b1, 1'b0, 8'h03, 16'h0000, 16'h1234);
        issue(1'b0, 1'b1, 8'hFF, 16'hBEEF, 16'h0000);
        chk("memFF", {16'd0, mem[255]}, 32'h0000_BEEF);
        chk("mem0_untouched", {16'd0, mem[0]}, 32'h0000_0000);
        issue(1'b0, 1'b0, 8'hFF, 16'h0000, 16'hBEEF);
        issue(1'b0, 1'b0, 8'h00, 16'h0000, 16'h0000);

        // Simultaneous held requests after reset: A, B, A, B three cycles apart.
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        held_a = 16'h0000;
        held_b = 16'h0000;
        drive(1'b0, 1'b1, 1'b0, 8'h03, 16'h0000);
        drive(1'b1, 1'b1, 1'b0, 8'hFF, 16'h0000);
        expect_ack(1'b0, 1'b0, 16'h1234, cyc + 2);
        expect_ack(1'b1, 1'b0, 16'hBEEF, cyc + 5);
        expect_ack(1'b0, 1'b0, 16'h1234, cyc + 8);
        expect_ack(1'b1, 1'b0, 16'hBEEF, cyc + 11);
        repeat (11) @(negedge i_clk);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
        repeat (3) @(negedge i_clk);
        chk("rr_queue_drained", sb.size(), 32'd0);

        // Reset lands on the ACCESS of a write: aborted, then re-arbitrated after release.
        drive(1'b0, 1'b1, 1'b1, 8'h10, 16'h5555);
        @(negedge i_clk);
        chk("abort_access_rw", {31'd0, bus.o_mem_rw}, 32'd1);
        i_rst = 1'b1;
        @(negedge i_clk);
        check_reset_outputs("abort");
        held_a = 16'h0000;
        held_b = 16'h0000;
        i_rst = 1'b0;
        expect_ack(1'b0, 1'b1, 16'h0000, cyc + 2);
        @(negedge i_clk);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        repeat (2) @(negedge i_clk);
        issue(1'b0, 1'b0, 8'h10, 16'h0000, 16'h5555);

        repeat (3) @(negedge i_clk);
        chk("final_queue_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter BITS, default 16, data word width for both requesters and the memory port.
REQ-002 Parameter ADDRW, default 8, address width; 256 words addressable.
REQ-003 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_a_req / i_b_req  input  1 each  access request from requester A / B.
REQ-006 i_a_rw / i_b_rw  input  1 each  LOW read, HIGH write.
REQ-007 i_a_addr / i_b_addr  input  ADDRW each  word address.
REQ-008 i_a_data / i_b_data  input  BITS each  write data.
REQ-009 o_a_ack / o_b_ack  output  1 each  one-cycle completion pulse.
REQ-010 o_a_data / o_b_data  output  BITS each  read data, held until that requester's next read completes.
REQ-011 o_mem_rw  output  1  memory write enable, LOW read, HIGH write.
REQ-012 o_mem_addr  output  ADDRW  memory address.
REQ-013 o_mem_data  output  BITS  memory write data.
REQ-014 i_mem_data  input  BITS  memory read data, combinational from o_mem_addr.
REQ-015 o_busy  output  1  HIGH whenever state is not IDLE.

Function
REQ-016 FSM states IDLE, ACCESS, DONE; every output is driven from registers only.
REQ-017 IDLE: with no request asserted, remain in IDLE with o_mem_rw LOW.
REQ-018 IDLE with a request: latch winner id, rw, addr, data into o_mem_rw/o_mem_addr/o_mem_data; go to ACCESS.
REQ-019 Arbitration: only one requesting -> that requester wins; both requesting -> the requester not granted last wins (round-robin).
REQ-020 Last-grant pointer resets to B, so A wins the first simultaneous contest after reset.
REQ-021 ACCESS lasts exactly one cycle; o_mem_rw is HIGH only during ACCESS of a write; memory commits at the edge leaving ACCESS.
REQ-022 Edge leaving ACCESS on a read: capture i_mem_data into the winner's o_x_data; the other requester's o_x_data is unchanged.
REQ-023 Edge leaving ACCESS: o_mem_rw returns LOW; state goes to DONE.
REQ-024 DONE: winner's o_x_ack HIGH for exactly this cycle; update last-grant pointer; return to IDLE.
REQ-025 Latency: request sampled at edge N -> ACCESS in cycle N+1 -> ack in cycle N+2; next grant sampled no earlier than edge N+3.
REQ-026 Requester inputs are sampled only in IDLE; changes during ACCESS/DONE are ignored.
REQ-027 Request still HIGH in IDLE after its ack -> treated as a new request and arbitrated normally.
REQ-028 Write data appears on o_x_data never; o_x_data changes only on read completion.
REQ-029 Both acks are never HIGH in the same cycle; at most one access is in flight.
REQ-030 Address wrap: none; full ADDRW range passes through unmodified, 8'hFF valid.

Reset
REQ-031 i_rst HIGH at an edge: state IDLE, o_mem_rw 0, o_mem_addr 0, o_mem_data 0, o_a_ack 0, o_b_ack 0, o_a_data 0, o_b_data 0, o_busy 0, last-grant pointer B.
REQ-032 Reset during ACCESS aborts the access: o_mem_rw LOW from the reset edge, no ack issued, requests re-arbitrated after reset releases.
REQ-033 Reset has priority over every request input.

Verification
REQ-034 A write addr 8'h03 data 16'h1234, B idle -> o_mem_rw HIGH for one cycle at cycle N+1, o_a_ack at N+2, memory[3]=16'h1234.
REQ-035 B read addr 8'h03 after REQ-034 -> o_b_data 16'h1234 and o_b_ack at N+2; o_a_data unchanged.
REQ-036 A and B request simultaneously and hold HIGH after reset -> grants A, B, A, B; acks 3 cycles apart, never overlapping.
REQ-037 A write addr 8'hFF data 16'hBEEF, then A read 8'hFF -> o_a_data 16'hBEEF; no wrap to address 0.
REQ-038 i_rst pulsed during ACCESS of a write -> no ack, o_mem_rw LOW from the reset edge, all outputs at REQ-031 values.
REQ-039 Requester changes addr and data during ACCESS -> completed access uses the values latched in IDLE.
